// File: rtl/nand4_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : nand4_resp_checker
//  Description : Response checker for NAND4 DUV variants. Captures each applied
//                4-bit vector on a valid strobe and waits a settle window. It
//                then compares the DUV output with ~(a&b&c&d) and accumulates
//                vector count, saturating error count, 16-entry coverage and
//                the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module nand4_resp_checker #(
  parameter int N_VEC      = 16,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 8,
  parameter int VCNT_W     = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic              i_a,
  input  logic              i_b,
  input  logic              i_c,
  input  logic              i_d,
  input  logic              i_f,
  output logic              o_ready,
  output logic [VCNT_W-1:0] o_vec_cnt,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [15:0]       o_cov,
  output logic              o_cov_full,
  output logic              o_first_err_vld,
  output logic [3:0]        o_first_err_vec,
  output logic              o_first_err_f,
  output logic              o_overrun,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // With no settle window the captured vector goes straight to the compare.
  localparam logic [2:0]        S_AFTER_CAP = (SETTLE_CYC > 0) ? S_WAIT : S_CHECK;
  localparam logic [3:0]        SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
  localparam logic [VCNT_W-1:0] N_VEC_C     = VCNT_W'(N_VEC);
  localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};

  logic [2:0]        state_q,   state_d;
  logic [3:0]        vec_q,     vec_d;
  logic [3:0]        settle_q,  settle_d;
  logic [VCNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [15:0]       cov_q,     cov_d;
  logic              fe_vld_q,  fe_vld_d;
  logic [3:0]        fe_vec_q,  fe_vec_d;
  logic              fe_f_q,    fe_f_d;
  logic              ovr_q,     ovr_d;

  logic [3:0]        w_in_vec;
  logic              w_exp;
  logic              w_mismatch;
  logic [VCNT_W-1:0] w_vec_cnt_inc;

  assign w_in_vec      = {i_a, i_b, i_c, i_d};
  assign w_exp         = ~&vec_q;
  // Case inequality so an unknown DUV output is treated as a failure.
  assign w_mismatch    = (i_f !== w_exp);
  assign w_vec_cnt_inc = vec_cnt_q + VCNT_W'(1);

  // Next-state and result-update logic; i_start overrides every state.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    cov_d     = cov_q;
    fe_vld_d  = fe_vld_q;
    fe_vec_d  = fe_vec_q;
    fe_f_d    = fe_f_q;
    ovr_d     = ovr_q;

    if (i_start) begin
      state_d   = S_ARMED;
      vec_d     = 4'd0;
      settle_d  = 4'd0;
      vec_cnt_d = '0;
      err_cnt_d = '0;
      cov_d     = 16'h0000;
      fe_vld_d  = 1'b0;
      fe_vec_d  = 4'd0;
      fe_f_d    = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ARMED: begin
          if (i_valid) begin
            vec_d    = w_in_vec;
            settle_d = 4'd0;
            state_d  = S_AFTER_CAP;
          end
        end
        S_WAIT: begin
          if (i_valid) ovr_d = 1'b1;
          if (settle_q == SETTLE_LAST) begin
            state_d = S_CHECK;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        S_CHECK: begin
          if (i_valid) ovr_d = 1'b1;
          vec_cnt_d     = w_vec_cnt_inc;
          cov_d[vec_q]  = 1'b1;
          if (w_mismatch) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!fe_vld_q) begin
              fe_vld_d = 1'b1;
              fe_vec_d = vec_q;
              fe_f_d   = i_f;
            end
          end
          state_d = (w_vec_cnt_inc == N_VEC_C) ? S_DONE : S_ARMED;
        end
        S_DONE: begin
          if (i_valid) ovr_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      vec_q     <= 4'd0;
      settle_q  <= 4'd0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      cov_q     <= 16'h0000;
      fe_vld_q  <= 1'b0;
      fe_vec_q  <= 4'd0;
      fe_f_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      cov_q     <= cov_d;
      fe_vld_q  <= fe_vld_d;
      fe_vec_q  <= fe_vec_d;
      fe_f_q    <= fe_f_d;
      ovr_q     <= ovr_d;
    end
  end

  // Every output is a register or a decode of registers only.
  assign o_ready         = (state_q == S_ARMED);
  assign o_done          = (state_q == S_DONE);
  assign o_vec_cnt       = vec_cnt_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_cov           = cov_q;
  assign o_cov_full      = &cov_q;
  assign o_first_err_vld = fe_vld_q;
  assign o_first_err_vec = fe_vec_q;
  assign o_first_err_f   = fe_f_q;
  assign o_overrun       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_nand4_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nand4_resp_checker
//  Description : Self-checking bench for nand4_resp_checker. A second instance
//                with a 2-bit error counter shares all stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nand4_resp_checker;

  localparam int S     = 1;
  localparam int NV    = 16;

  logic clk = 1'b0;
  logic rst, start, valid, a, b, c, d, f;

  logic        ready, cov_full, fe_vld, fe_f, ovr, done;
  logic [4:0]  vec_cnt;
  logic [7:0]  err_cnt;
  logic [15:0] cov;
  logic [3:0]  fe_vec;

  logic        ready2, cov_full2, fe_vld2, fe_f2, ovr2, done2;
  logic [4:0]  vec_cnt2;
  logic [1:0]  err_cnt2;
  logic [15:0] cov2;
  logic [3:0]  fe_vec2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit       m_started, m_done, m_fv, m_ff, m_ovr;
  int       m_busy, m_cnt, m_err;
  bit [15:0] m_cov;
  bit [3:0] m_vec, m_fvec;

  nand4_resp_checker #(.N_VEC(NV), .SETTLE_CYC(S), .ERR_W(8), .VCNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_f(f),
    .o_ready(ready), .o_vec_cnt(vec_cnt), .o_err_cnt(err_cnt), .o_cov(cov),
    .o_cov_full(cov_full), .o_first_err_vld(fe_vld), .o_first_err_vec(fe_vec),
    .o_first_err_f(fe_f), .o_overrun(ovr), .o_done(done));

  nand4_resp_checker #(.N_VEC(NV), .SETTLE_CYC(S), .ERR_W(2), .VCNT_W(5)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_f(f),
    .o_ready(ready2), .o_vec_cnt(vec_cnt2), .o_err_cnt(err_cnt2), .o_cov(cov2),
    .o_cov_full(cov_full2), .o_first_err_vld(fe_vld2), .o_first_err_vec(fe_vec2),
    .o_first_err_f(fe_f2), .o_overrun(ovr2), .o_done(done2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_done = 0; m_fv = 0; m_ff = 0; m_ovr = 0; m_fvec = 0;
    m_busy = 0; m_cnt = 0; m_err = 0; m_cov = 0;
  endtask

  // Model: a run has a busy window of 1+S edges after each accepted vector;
  // the result lands on the edge that closes the window.
  task automatic model_edge(input bit st, va, input bit [3:0] v, input bit fv);
    bit mis;
    if (rst) begin
      m_clear(); m_started = 0;
    end else if (st) begin
      m_clear(); m_started = 1;
    end else if (m_started) begin
      if (m_done) begin
        if (va) m_ovr = 1;
      end else if (m_busy > 0) begin
        if (va) m_ovr = 1;
        m_busy--;
        if (m_busy == 0) begin
          mis = (fv != !(m_vec == 4'hF));
          m_cnt++;
          m_cov[m_vec] = 1'b1;
          if (mis) begin
            m_err++;
            if (!m_fv) begin m_fv = 1; m_fvec = m_vec; m_ff = fv; end
          end
          if (m_cnt == NV) m_done = 1;
        end
      end else if (va) begin
        m_vec = v; m_busy = 1 + S;
      end
    end
  endtask

  // One clock: apply inputs, update the model at the edge, check 1 unit later.
  task automatic tick(input bit st, va, input bit [3:0] v, input bit fv, input bit rs);
    start = st; valid = va; {a, b, c, d} = v; f = fv; rst = rs;
    @(posedge clk);
    model_edge(st, va, v, fv);
    #1;
    chk("ready",    ready,    m_started && !m_done && m_busy == 0);
    chk("done",     done,     m_done);
    chk("vec_cnt",  vec_cnt,  m_cnt);
    chk("err_cnt",  err_cnt,  m_err > 255 ? 255 : m_err);
    chk("cov",      cov,      m_cov);
    chk("cov_full", cov_full, m_cov == 16'hFFFF);
    chk("fe_vld",   fe_vld,   m_fv);
    chk("fe_vec",   fe_vec,   m_fv ? m_fvec : 4'h0);
    chk("fe_f",     fe_f,     m_fv ? m_ff : 1'b0);
    chk("overrun",  ovr,      m_ovr);
    chk("err_cnt2", err_cnt2, m_err > 3 ? 3 : m_err);
    chk("done2",    done2,    m_done);
  endtask

  // Apply one vector and idle through its settle/check window.
  task automatic run_vec(input bit [3:0] v, input bit fv);
    tick(0, 1, v, fv, 0);
    for (int k = 0; k < 1 + S; k++) tick(0, 0, v, fv, 0);
  endtask

  initial begin
    bit [3:0] v;
    bit       fv;
    int       guard;
    m_started = 0; m_vec = 0; m_clear();
    start = 0; valid = 0; {a, b, c, d} = 4'h0; f = 0; rst = 1;

    // Reset
    tick(0, 0, 4'h0, 0, 1);
    tick(0, 0, 4'h0, 0, 1);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_ready",   ready,   0);
    tick(0, 1, 4'h5, 0, 0);            // i_valid in IDLE ignored
    chk("idle_ovr", ovr, 0);

    // 1: clean sweep
    tick(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      run_vec(v, !(v == 4'hF));
    end
    chk("t1_done", done, 1);
    chk("t1_cnt", vec_cnt, 16);
    chk("t1_err", err_cnt, 0);
    chk("t1_cov", cov, 16'hFFFF);
    chk("t1_full", cov_full, 1);
    chk("t1_fev", fe_vld, 0);

    // 2: faults at index 15 (f=1) and 3 (f=0)
    tick(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      fv = !(v == 4'hF);
      if (i == 15) fv = 1;
      if (i == 3)  fv = 0;
      run_vec(v, fv);
    end
    chk("t2_err", err_cnt, 2);
    chk("t2_fevec", fe_vec, 4'h3);
    chk("t2_fef", fe_f, 0);

    // 3: back-to-back valid, random vectors
    tick(1, 0, 4'h0, 0, 0);
    guard = 0;
    while (!m_done && guard < 200) begin
      v = 4'($urandom_range(0, 15));
      tick(0, 1, v, !(v == 4'hF), 0);
      guard++;
    end
    chk("t3_guard", guard < 200, 1);
    chk("t3_ovr", ovr, 1);

    // 4: every vector wrong; 2-bit counter saturates
    tick(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      run_vec(v, v == 4'hF);
    end
    chk("t4_err2", err_cnt2, 3);
    chk("t4_err", err_cnt, 16);

    // 5: start mid-WAIT after 7 vectors, then a random rerun
    tick(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 7; i++) run_vec(4'(i), !(i == 15));
    tick(0, 1, 4'h7, 1, 0);
    tick(1, 0, 4'h7, 1, 0);
    chk("t5_cnt", vec_cnt, 0);
    chk("t5_cov", cov, 0);
    chk("t5_ready", ready, 1);
    for (int i = 0; i < 16; i++) begin
      v  = 4'($urandom_range(0, 15));
      fv = !(v == 4'hF);
      if ($urandom_range(0, 3) == 0) fv = !fv;
      run_vec(v, fv);
    end
    chk("t5_done", done, 1);

    // 6: reset in DONE, valid ignored, then reset in CHECK
    tick(0, 0, 4'h0, 0, 1);
    chk("t6_done", done, 0);
    chk("t6_cnt", vec_cnt, 0);
    tick(0, 1, 4'h2, 1, 0);
    tick(0, 1, 4'h9, 1, 0);
    chk("t6_ovr", ovr, 0);
    chk("t6_cnt2", vec_cnt, 0);
    tick(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) run_vec(4'(i + 8), 1);
    tick(0, 1, 4'hB, 1, 0);          // capture
    tick(0, 0, 4'hB, 1, 0);          // now in CHECK
    tick(0, 0, 4'hB, 1, 1);          // reset wins
    chk("t6_cnt3", vec_cnt, 0);
    chk("t6_cov", cov, 0);
    tick(0, 1, 4'h1, 1, 0);
    tick(0, 0, 4'h1, 1, 0);
    chk("t6_ready", ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
